// File: rtl/prog_delay_line.sv
// prog_delay_line: multi-lane delay line with a runtime-selected tap.
// Optional DLY_ZERO_BYPASS_EN makes delay 0 a combinational bypass.
module prog_delay_line #(
    parameter int DATA_W        = 16,
    parameter int CHANNELS      = 4,
    parameter int MAX_DELAY     = 32,
    parameter int DEFAULT_DELAY = 5,
    parameter int SEL_W         = $clog2(MAX_DELAY + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         delay_load,
    input  logic [SEL_W-1:0]             delay_sel,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         primed,
    output logic [SEL_W-1:0]             cur_delay,
    output logic                         cfg_err
);

    localparam int BW = CHANNELS * DATA_W;
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_DELAY);

    typedef enum logic {S_FILL, S_STEADY} state_t;

    logic [MAX_DELAY-1:0] r_vld;
    logic [BW-1:0]        r_dat [MAX_DELAY];
    logic [SEL_W-1:0]     r_cur;
    logic [SEL_W-1:0]     r_cnt;
    logic                 r_cfg_err;
    state_t               r_state;

    state_t               w_state_n;
    logic [SEL_W-1:0]     w_cnt_n;
    logic [SEL_W-1:0]     w_cur_n;
    logic [SEL_W-1:0]     w_sel_clamp;
    logic                 w_sel_bad;
    logic                 w_tap_v;
    logic [BW-1:0]        w_tap_d;

    // Clamp the requested delay into the legal range and flag bad requests
    always_comb begin
        w_sel_bad   = 1'b0;
        w_sel_clamp = delay_sel;
        if (delay_sel > MAX_SEL) begin
            w_sel_bad   = 1'b1;
            w_sel_clamp = MAX_SEL;
        end
`ifndef DLY_ZERO_BYPASS_EN
        else if (delay_sel == '0) begin
            w_sel_bad   = 1'b1;
            w_sel_clamp = SEL_W'(1);
        end
`endif
    end

    // Shift stages on enable; a load flushes valids before the new beat lands
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int k = 0; k < MAX_DELAY; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            if (en) begin
                r_dat[0] <= in_data;
                for (int k = 1; k < MAX_DELAY; k++) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
            if (delay_load) begin
                r_vld <= {{(MAX_DELAY-1){1'b0}}, en & in_valid};
            end else if (en) begin
                r_vld <= {r_vld[MAX_DELAY-2:0], in_valid};
            end
        end
    end

    // Fill tracking: count enabled cycles until the pipe holds cur_delay beats
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cur_n   = r_cur;
        if (delay_load) begin
            w_cur_n   = w_sel_clamp;
            w_cnt_n   = (en && w_sel_clamp != '0) ? SEL_W'(1) : '0;
            w_state_n = (w_cnt_n >= w_cur_n) ? S_STEADY : S_FILL;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (en && r_cnt < r_cur) begin
                        w_cnt_n = r_cnt + SEL_W'(1);
                    end
                    if (w_cnt_n >= r_cur) begin
                        w_state_n = S_STEADY;
                    end
                end
                S_STEADY: begin
                    w_state_n = S_STEADY;
                end
            endcase
        end
    end

    // Delay configuration and fill-state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FILL;
            r_cnt     <= '0;
            r_cur     <= DEF_SEL;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_cur     <= w_cur_n;
            r_cfg_err <= delay_load & w_sel_bad;
        end
    end

    // Select the stage at depth cur_delay
    always_comb begin
        w_tap_v = 1'b0;
        w_tap_d = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (r_cur == SEL_W'(k + 1)) begin
                w_tap_v = r_vld[k];
                w_tap_d = r_dat[k];
            end
        end
`ifdef DLY_ZERO_BYPASS_EN
        if (r_cur == '0) begin
            w_tap_v = in_valid & en;
            w_tap_d = in_data;
        end
`endif
    end

    assign out_valid = w_tap_v;
    assign out_data  = w_tap_v ? w_tap_d : '0;
    assign primed    = (r_state == S_STEADY);
    assign cur_delay = r_cur;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: scoreboard bench with a history-array reference model.
// Honors DLY_ZERO_BYPASS_EN when the design is built with it.
module tb_prog_delay_line;

    localparam int DW   = 16;
    localparam int CH   = 4;
    localparam int MAXD = 32;
    localparam int DEFD = 5;
    localparam int SW   = $clog2(MAXD + 1);
    localparam int BW   = DW * CH;
`ifdef DLY_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          delay_load = 1'b0;
    logic [SW-1:0] delay_sel = '0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          primed;
    logic [SW-1:0] cur_delay;
    logic          cfg_err;

    prog_delay_line #(
        .DATA_W(DW), .CHANNELS(CH), .MAX_DELAY(MAXD),
        .DEFAULT_DELAY(DEFD), .SEL_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .delay_load(delay_load), .delay_sel(delay_sel),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .primed(primed), .cur_delay(cur_delay), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [BW-1:0] d;
        logic          p;
        logic [SW-1:0] c;
        logic          e;
        int            n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycno  = 0;
    bit   armed  = 0;

    // Reference model: hist[0] is the newest accepted beat
    logic          hv [MAXD];
    logic [BW-1:0] hd [MAXD];
    int            m_cur;
    int            m_cnt;
    logic          m_err;

    task automatic model_edge(input logic r, e, l, input int s,
                              input logic v, input logic [BW-1:0] d);
        if (r) begin
            for (int k = 0; k < MAXD; k++) begin
                hv[k] = 1'b0;
                hd[k] = '0;
            end
            m_cur = DEFD;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (l) begin
                if (s > MAXD) begin
                    m_cur = MAXD;
                    m_err = 1'b1;
                end else if (s == 0 && !BYP) begin
                    m_cur = 1;
                    m_err = 1'b1;
                end else begin
                    m_cur = s;
                end
                for (int k = 0; k < MAXD; k++) hv[k] = 1'b0;
                m_cnt = 0;
            end
            if (e) begin
                for (int k = MAXD - 1; k > 0; k--) begin
                    hv[k] = hv[k-1];
                    hd[k] = hd[k-1];
                end
                hv[0] = v;
                hd[0] = d;
                if (m_cnt < m_cur) m_cnt++;
            end
        end
    endtask

    function automatic exp_t predict(input logic e, v, input logic [BW-1:0] d);
        exp_t x;
        if (m_cur == 0) begin
            x.v = v & e;
            x.d = x.v ? d : '0;
        end else begin
            x.v = hv[m_cur-1];
            x.d = x.v ? hd[m_cur-1] : '0;
        end
        x.p = (m_cnt >= m_cur);
        x.c = SW'(m_cur);
        x.e = m_err;
        x.n = cycno;
        return x;
    endfunction

    // Apply one cycle of inputs, queue the expected outputs, then clock
    task automatic cyc(input logic r, e, l, input int s,
                       input logic v, input logic [BW-1:0] d);
        reset      = r;
        en         = e;
        delay_load = l;
        delay_sel  = SW'(s);
        in_valid   = v;
        in_data    = d;
        if (armed) sb.push_back(predict(e, v, d));
        @(posedge clk);
        model_edge(r, e, l, s, v, d);
        armed = 1;
        cycno++;
        #1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (out_valid !== x.v || out_data !== x.d ||
                    primed !== x.p || cur_delay !== x.c ||
                    cfg_err !== x.e) begin
                    errors++;
                    $display("FAIL cyc%0d got v=%0b d=%h p=%0b cur=%0d err=%0b want v=%0b d=%h p=%0b cur=%0d err=%0b",
                             x.n, out_valid, out_data, primed, cur_delay,
                             cfg_err, x.v, x.d, x.p, x.c, x.e);
                end
            end
        end
    end

    initial begin
        int n;
        n = 1;
        // reset and stream incrementing data at default delay
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 1, 0, 0, 1, 64'hdead);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 0, 1, BW'(n));
            n++;
        end
        // reprogram to 12 mid-stream
        cyc(0, 1, 1, 12, 1, BW'(n));
        n++;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 0, 1, BW'(n));
            n++;
        end
        // delay 3 with en toggling
        cyc(0, 0, 1, 3, 0, '0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, (i % 2 == 0), 0, 0, 1, BW'(n));
            n++;
        end
        // out-of-range request clamps to max
        cyc(0, 1, 1, 40, 1, BW'(n));
        n++;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 0, 0, 1, BW'(n));
            n++;
        end
        // zero delay request
        cyc(0, 1, 1, 0, 1, BW'(n));
        n++;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0, 1, BW'(n));
            n++;
        end
        // reset with beats in flight
        cyc(0, 1, 1, 6, 1, BW'(n));
        n++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 1, BW'(n));
            n++;
        end
        cyc(1, 1, 0, 0, 1, 64'hbeef);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 0, 0, (i > 7), BW'(n));
            n++;
        end
        // random traffic
        for (int i = 0; i < 2500; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 39) == 0),
                int'($urandom_range(0, 40)),
                logic'($urandom_range(0, 1)),
                {$urandom, $urandom});
        end
        cyc(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
